// File: rtl/fp_div_normalize_if.sv
// Handshake bundle between the divider front end, the normalise/pack stage and the consumer.
// Carries the quotient/exponent/special bundle in and the packed IEEE-754 result out.
interface fp_div_normalize_if #(
    parameter int MW = 23,
    parameter int EW = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [MW:0]             quot_in;
    logic signed [EW+1:0]    exp_in;
    logic                    sign_in;
    logic                    is_nan;
    logic                    is_inf;
    logic                    is_zero;
    logic                    out_valid;
    logic                    out_ready;
    logic [EW+MW:0]          result;
    logic                    overflow;
    logic                    underflow;

    // Upstream/downstream side (producer of the bundle, consumer of the result)
    modport master (
        output in_valid, quot_in, exp_in, sign_in, is_nan, is_inf, is_zero, out_ready,
        input  in_ready, out_valid, result, overflow, underflow
    );

    // Normalise/pack stage side
    modport slave (
        input  in_valid, quot_in, exp_in, sign_in, is_nan, is_inf, is_zero, out_ready,
        output in_ready, out_valid, result, overflow, underflow
    );
endinterface

// File: rtl/fp_div_normalize.sv
// Post-divide normalise and pack: serially left-justifies the quotient one bit per cycle,
// range-checks the signed exponent and emits an IEEE-754 single over valid/ready.
module fp_div_normalize #(
    parameter int MW   = 23,
    parameter int EW   = 8,
    parameter int BIAS = 127
) (
    input  logic               clk,
    input  logic               rstn,
    fp_div_normalize_if.slave  bus
);
    localparam int XW = EW + 2;
    localparam int RW = 1 + EW + MW;

    // The all-ones exponent code equals twice the bias plus one for IEEE formats.
    localparam logic signed [XW-1:0] EXP_MAX  = XW'(2 * BIAS + 1);
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic [MW:0]          HIDDEN   = {1'b1, {MW{1'b0}}};
    localparam logic [RW-1:0]        QNAN     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_reg,  state_next;
    logic [MW:0]          q_reg,      q_next;
    logic signed [XW-1:0] exp_reg,    exp_next;
    logic                 sign_reg,   sign_next;
    logic                 nan_reg,    nan_next;
    logic                 inf_reg,    inf_next;
    logic                 zero_reg,   zero_next;
    logic [RW-1:0]        result_reg, result_next;
    logic                 ovf_reg,    ovf_next;
    logic                 unf_reg,    unf_next;
    logic                 valid_reg,  valid_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            q_reg      <= '0;
            exp_reg    <= '0;
            sign_reg   <= 1'b0;
            nan_reg    <= 1'b0;
            inf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            exp_reg    <= exp_next;
            sign_reg   <= sign_next;
            nan_reg    <= nan_next;
            inf_reg    <= inf_next;
            zero_reg   <= zero_next;
            result_reg <= result_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
            valid_reg  <= valid_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        exp_next    = exp_reg;
        sign_next   = sign_reg;
        nan_next    = nan_reg;
        inf_next    = inf_reg;
        zero_next   = zero_reg;
        result_next = result_reg;
        ovf_next    = ovf_reg;
        unf_next    = unf_reg;
        valid_next  = valid_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_next = bus.sign_in;
                    nan_next  = bus.is_nan;
                    inf_next  = bus.is_inf;
                    zero_next = bus.is_zero;
                    if (bus.is_nan || bus.is_inf || bus.is_zero) begin
                        q_next     = bus.quot_in;
                        exp_next   = bus.exp_in;
                        state_next = PACK;
                    end else if (bus.quot_in == '0) begin
                        // Rounding carried out of the divider: quotient is exactly 2.0
                        q_next     = HIDDEN;
                        exp_next   = bus.exp_in + EXP_ONE;
                        state_next = NORM;
                    end else begin
                        q_next     = bus.quot_in;
                        exp_next   = bus.exp_in;
                        state_next = NORM;
                    end
                end
            end

            NORM: begin
                if (q_reg[MW]) begin
                    state_next = PACK;
                end else begin
                    q_next   = {q_reg[MW-1:0], 1'b0};
                    exp_next = exp_reg - EXP_ONE;
                end
            end

            PACK: begin
                valid_next = 1'b1;
                ovf_next   = 1'b0;
                unf_next   = 1'b0;
                if (nan_reg) begin
                    result_next = QNAN;
                end else if (inf_reg) begin
                    result_next = {sign_reg, {EW{1'b1}}, {MW{1'b0}}};
                end else if (zero_reg) begin
                    result_next = {sign_reg, {EW{1'b0}}, {MW{1'b0}}};
                end else if (exp_reg >= EXP_MAX) begin
                    result_next = {sign_reg, {EW{1'b1}}, {MW{1'b0}}};
                    ovf_next    = 1'b1;
                end else if (exp_reg <= EXP_ZERO) begin
                    // No denormal support: flush to a signed zero
                    result_next = {sign_reg, {EW{1'b0}}, {MW{1'b0}}};
                    unf_next    = 1'b1;
                end else begin
                    result_next = {sign_reg, exp_reg[EW-1:0], q_reg[MW-1:0]};
                end
                state_next = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    valid_next = 1'b0;
                    ovf_next   = 1'b0;
                    unf_next   = 1'b0;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = valid_reg;
    assign bus.result    = result_reg;
    assign bus.overflow  = ovf_reg;
    assign bus.underflow = unf_reg;
endmodule

// File: tb/tb_fp_div_normalize.sv
// Directed-vector bench for fp_div_normalize: the driver pushes expected results into a
// scoreboard queue and an independent monitor pops and compares on each output handshake.
module tb_fp_div_normalize;
    logic clk;
    logic rstn;

    fp_div_normalize_if #(.MW(23), .EW(8)) bus ();

    fp_div_normalize #(.MW(23), .EW(8), .BIAS(127)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
        int          k;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Monitor: compares whenever the DUT completes an output handshake
    logic prev_valid = 1'b0;
    int   rise_cyc   = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_output: result=%h with empty scoreboard", bus.result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    tests++;
                    if (bus.result !== e.res || bus.overflow !== e.ovf || bus.underflow !== e.unf) begin
                        fails++;
                        $display("FAIL %s: got result=%h ovf=%b unf=%b, expected result=%h ovf=%b unf=%b",
                                 e.name, bus.result, bus.overflow, bus.underflow, e.res, e.ovf, e.unf);
                    end else begin
                        $display("[TB] %s: result=%h ovf=%b unf=%b ok", e.name, bus.result, bus.overflow, bus.underflow);
                    end
                    if (e.lat >= 0) begin
                        tests++;
                        if (rise_cyc - e.k != e.lat) begin
                            fails++;
                            $display("FAIL %s_latency: got %0d cycles, expected %0d", e.name, rise_cyc - e.k, e.lat);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input string name, input logic [23:0] q, input logic signed [9:0] e,
                        input logic s, input logic n, input logic i, input logic z,
                        input logic [31:0] res, input logic o, input logic u, input int lat);
        int w = 0;
        exp_t x;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            tests++; fails++;
            $display("FAIL %s_in_ready_timeout: in_ready=%b, required 1", name, bus.in_ready);
        end
        bus.quot_in  = q;
        bus.exp_in   = e;
        bus.sign_in  = s;
        bus.is_nan   = n;
        bus.is_inf   = i;
        bus.is_zero  = z;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        x.res = res; x.ovf = o; x.unf = u; x.lat = lat; x.k = cyc; x.name = name;
        sb.push_back(x);
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((sb.size() != 0 || bus.out_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (w >= 200) begin
            fails++;
            $display("FAIL %s_drain_timeout: %0d results outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    initial begin
        logic [31:0] snap_res;
        logic        snap_ovf, snap_unf;
        int          bad;
        int          w;

        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.quot_in   = '0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;
        bus.is_nan    = 1'b0;
        bus.is_inf    = 1'b0;
        bus.is_zero   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check1("reset_out_valid", bus.out_valid, 1'b0);
        check1("reset_in_ready", bus.in_ready, 1'b1);
        check1("reset_overflow", bus.overflow, 1'b0);
        check1("reset_underflow", bus.underflow, 1'b0);
        tests++;
        if (bus.result !== 32'h0) begin
            fails++;
            $display("FAIL reset_result: got %h, expected 00000000", bus.result);
        end
        rstn = 1'b1;

        //    name           quot        exp    s     nan   inf   zero  result        ovf   unf   lat
        send("norm_3_0",    24'hC00000, 10'sd128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 2);
        send("one_shift",   24'h400000, 10'sd128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3);
        send("carry",       24'h000000, 10'sd127, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 2);
        send("ovf_255",     24'h800000, 10'sd255, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 2);
        send("unf_0_neg",   24'h800000, 10'sd0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 2);
        send("nan_inf",     24'h123456, 10'sd100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 1'b0, 1'b0, -1);
        send("max_shift",   24'h000001, 10'sd150, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 25);
        send("exp_254",     24'h800000, 10'sd254, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F000000, 1'b0, 1'b0, 2);
        send("exp_1",       24'h800000, 10'sd1,   1'b0, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0, 2);
        send("shift_unf",   24'h400000, 10'sd1,   1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 3);
        send("inf_neg",     24'h800000, 10'sd10,  1'b1, 1'b0, 1'b1, 1'b0, 32'hFF800000, 1'b0, 1'b0, -1);
        send("zero_neg",    24'h800000, 10'sd10,  1'b1, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, -1);
        send("nan_neg",     24'h800000, 10'sd10,  1'b1, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 1'b0, 1'b0, -1);
        send("neg_mixed",   24'hA00000, 10'sd130, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC1200000, 1'b0, 1'b0, 2);
        send("ovf_300",     24'h800000, 10'sd300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 2);
        send("unf_neg_exp", 24'h800000, -10'sd5,  1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 2);
        send("zero_big_e",  24'h800000, 10'sd300, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, -1);
        drain("vectors");

        // Back-pressure: output must hold steady while out_ready is low
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send("hold", 24'hC00000, 10'sd128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 2);
        w = 0;
        while (!bus.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check1("hold_out_valid_seen", bus.out_valid, 1'b1);
        snap_res = bus.result;
        snap_ovf = bus.overflow;
        snap_unf = bus.underflow;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.result !== snap_res || bus.overflow !== snap_ovf || bus.underflow !== snap_unf
                || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_stable: %0d unstable cycles, expected 0", bad);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain("hold");
        check1("hold_in_ready_after", bus.in_ready, 1'b1);

        // Reset in the middle of a long normalisation
        @(negedge clk);
        bus.quot_in  = 24'h000001;
        bus.exp_in   = 10'sd150;
        bus.sign_in  = 1'b0;
        bus.is_nan   = 1'b0;
        bus.is_inf   = 1'b0;
        bus.is_zero  = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check1("norm_busy_in_ready", bus.in_ready, 1'b0);
        rstn = 1'b0;
        #1;
        check1("abort_out_valid", bus.out_valid, 1'b0);
        check1("abort_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL abort_no_output: out_valid high %0d cycles, expected 0", bad);
        end
        check1("abort_idle", bus.in_ready, 1'b1);

        send("after_abort", 24'h400000, 10'sd128, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3);
        drain("after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
